// File: rtl/pmp_seq_checker.sv
// ---------------------------------------------------------------------------
// pmp_seq_checker
//
// Iterative PMP permission checker. One PMP address-decode datapath is shared
// by all entries: the entries are scanned in priority order, one per cycle,
// and the first matching entry decides the outcome. A single request is in
// flight at a time (valid/ready on both the request and the response side).
//
// Ports
//   clk              clock
//   reset            synchronous, active-high reset
//   ReqValid         request valid
//   ReqReady         request accepted when ReqValid & ReqReady
//   PhysicalAddress  access address (PA_BITS)
//   Size             log2 of the access size in bytes
//   ReadAccess       read access  (access type is one-hot)
//   WriteAccess      write access
//   ExecuteAccess    execute access
//   PrivilegeMode    11 = M, 01 = S, 00 = U
//   PMPCfg           flattened config bytes {L, 2'b0, A[1:0], X, W, R}, entry i
//                    at [8i+7:8i]
//   PMPAdr           flattened pmpaddr values, (PA_BITS-2) bits per entry
//   CfgWrite         pulse on any pmpcfg/pmpaddr CSR write; restarts a scan
//   RspValid         response valid
//   RspReady         response consumed
//   Fault            access fault
//   Matched          some entry matched
//   MatchIdx         lowest matching entry index
// ---------------------------------------------------------------------------
module pmp_seq_checker #(
    parameter int PA_BITS     = 34,
    parameter int PMP_ENTRIES = 16,
    parameter int IDXW        = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ReqValid,
    output logic                              ReqReady,
    input  logic [PA_BITS-1:0]                PhysicalAddress,
    input  logic [1:0]                        Size,
    input  logic                              ReadAccess,
    input  logic                              WriteAccess,
    input  logic                              ExecuteAccess,
    input  logic [1:0]                        PrivilegeMode,
    input  logic [PMP_ENTRIES*8-1:0]          PMPCfg,
    input  logic [PMP_ENTRIES*(PA_BITS-2)-1:0] PMPAdr,
    input  logic                              CfgWrite,
    output logic                              RspValid,
    input  logic                              RspReady,
    output logic                              Fault,
    output logic                              Matched,
    output logic [IDXW-1:0]                   MatchIdx
);

    localparam int             AW       = PA_BITS - 2;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PMP_ENTRIES - 1);
    localparam logic [1:0]     PRIV_M   = 2'b11;
    localparam logic [1:0]     A_OFF    = 2'b00;
    localparam logic [1:0]     A_TOR    = 2'b01;
    localparam logic [1:0]     A_NAPOT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Captured request
    logic [PA_BITS-1:0] r_pa;
    logic [1:0]         r_size;
    logic               r_rd;
    logic               r_wr;
    logic               r_ex;
    logic [1:0]         r_priv;

    // Scan state and held response
    logic [IDXW-1:0]    r_idx;
    logic               r_ge;       // PA >= lower bound of the entry under test
    logic               r_any;      // some scanned entry was active
    logic               r_fault;
    logic               r_matched;
    logic [IDXW-1:0]    r_match_idx;

    // Per-entry views of the flattened configuration
    logic               w_lock_arr [PMP_ENTRIES];
    logic [1:0]         w_mode_arr [PMP_ENTRIES];
    logic [2:0]         w_perm_arr [PMP_ENTRIES];
    logic [AW-1:0]      w_adr_arr  [PMP_ENTRIES];

    for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_entry
        logic w_unused_rsvd;
        assign w_lock_arr[g] = PMPCfg[8*g+7];
        assign w_mode_arr[g] = PMPCfg[8*g+3 +: 2];
        assign w_perm_arr[g] = PMPCfg[8*g +: 3];
        assign w_adr_arr[g]  = PMPAdr[AW*g +: AW];
        // Bits 6:5 of each config byte are reserved and carry no meaning here.
        assign w_unused_rsvd = ^PMPCfg[8*g+5 +: 2];
    end

    // ---------------------------------------------------------------------
    // Shared decode datapath for entry r_idx
    // ---------------------------------------------------------------------
    logic               w_lock;
    logic [1:0]         w_mode;
    logic [2:0]         w_perm;
    logic [AW-1:0]      w_adr;
    logic               w_is_napot;
    logic [AW-1:0]      w_mask;
    logic [AW-1:0]      w_mask_eff;
    logic               w_napot_hit;
    logic               w_tor_lt;
    logic               w_entry_match;
    logic               w_active;
    logic               w_any_next;
    logic               w_enforce;
    logic               w_perm_fault;
    logic               w_last;

    assign w_lock     = w_lock_arr[r_idx];
    assign w_mode     = w_mode_arr[r_idx];
    assign w_perm     = w_perm_arr[r_idx];
    assign w_adr      = w_adr_arr[r_idx];
    assign w_is_napot = (w_mode == A_NAPOT);

    // Adding 1 to a NAPOT address flips its trailing ones plus the first zero,
    // so the XOR yields exactly the "don't care" word bits. For NA4 the mask
    // is zero; an 8-byte access additionally ignores PA bit 2.
    assign w_mask      = (w_adr + AW'(w_is_napot)) ^ w_adr;
    assign w_mask_eff  = w_mask | AW'(r_size == 2'b11);
    assign w_napot_hit = (((r_pa[PA_BITS-1:2] ^ w_adr) & ~w_mask_eff) == '0);
    assign w_tor_lt    = (r_pa < {w_adr, 2'b00});

    always_comb begin
        unique case (w_mode)
            A_OFF:   w_entry_match = 1'b0;
            A_TOR:   w_entry_match = r_ge & w_tor_lt;
            default: w_entry_match = w_napot_hit;
        endcase
    end

    assign w_active     = (w_mode != A_OFF);
    assign w_any_next   = r_any | w_active;
    assign w_enforce    = (r_priv != PRIV_M) | w_lock;
    assign w_perm_fault = (r_rd & ~w_perm[0]) | (r_wr & ~w_perm[1]) | (r_ex & ~w_perm[2]);
    assign w_last       = (r_idx == LAST_IDX);

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    logic w_accept;
    logic w_restart;
    logic w_hit;
    logic w_miss;
    logic w_step;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_restart    = 1'b0;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_step       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (ReqValid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                // A config write invalidates the partial scan and wins over a
                // match decided from the old configuration in the same cycle.
                if (CfgWrite) begin
                    w_restart = 1'b1;
                end else if (w_entry_match) begin
                    w_hit        = 1'b1;
                    w_next_state = S_RESP;
                end else if (w_last) begin
                    w_miss       = 1'b1;
                    w_next_state = S_RESP;
                end else begin
                    w_step = 1'b1;
                end
            end
            S_RESP: begin
                if (RspReady) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Scan bookkeeping and the held response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_ge        <= 1'b0;
            r_any       <= 1'b0;
            r_fault     <= 1'b0;
            r_matched   <= 1'b0;
            r_match_idx <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= '0;
                r_ge  <= 1'b1;          // address >= 0 for entry 0
                r_any <= 1'b0;
            end else if (w_restart) begin
                r_idx <= '0;
                r_ge  <= 1'b0;
                r_any <= 1'b0;
            end else if (r_state == S_SCAN) begin
                // The TOR lower bound of entry i+1 is pmpaddr[i], active or not.
                r_ge  <= ~w_tor_lt;
                r_any <= w_any_next;
                if (w_step) begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end

            if (w_hit) begin
                r_matched   <= 1'b1;
                r_match_idx <= r_idx;
                r_fault     <= w_enforce & w_perm_fault;
            end else if (w_miss) begin
                r_matched   <= 1'b0;
                r_match_idx <= '0;
                r_fault     <= (r_priv != PRIV_M) & w_any_next;
            end
        end
    end

    // NOTE: the request capture registers are deliberately not reset; they
    // are always loaded on accept before anything reads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pa   <= PhysicalAddress;
            r_size <= Size;
            r_rd   <= ReadAccess;
            r_wr   <= WriteAccess;
            r_ex   <= ExecuteAccess;
            r_priv <= PrivilegeMode;
        end
    end

    assign ReqReady = (r_state == S_IDLE) & ~reset;
    assign RspValid = (r_state == S_RESP);
    assign Fault    = r_fault;
    assign Matched  = r_matched;
    assign MatchIdx = r_match_idx;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_pmp_seq_checker
//
// Self-checking bench for pmp_seq_checker. A driver issues directed and
// random requests; for each one a region-based reference model computes the
// expected decision and the cycle in which the response must appear, and
// pushes it into a scoreboard. An independent monitor pops and compares
// whenever the DUT raises RspValid, and checks handshake behaviour.
// ---------------------------------------------------------------------------
module tb_pmp_seq_checker;

    localparam int PA_BITS = 34;
    localparam int N       = 16;
    localparam int AW      = PA_BITS - 2;
    localparam int IDXW    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                ReqValid;
    logic                ReqReady;
    logic [PA_BITS-1:0]  PhysicalAddress;
    logic [1:0]          Size;
    logic                ReadAccess;
    logic                WriteAccess;
    logic                ExecuteAccess;
    logic [1:0]          PrivilegeMode;
    wire  [N*8-1:0]      PMPCfg;
    wire  [N*AW-1:0]     PMPAdr;
    logic                CfgWrite;
    logic                RspValid;
    logic                RspReady;
    logic                Fault;
    logic                Matched;
    logic [IDXW-1:0]     MatchIdx;

    logic [7:0]    cfg [N];
    logic [AW-1:0] adr [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign PMPCfg[8*g +: 8]  = cfg[g];
        assign PMPAdr[AW*g +: AW] = adr[g];
    end

    pmp_seq_checker #(
        .PA_BITS    (PA_BITS),
        .PMP_ENTRIES(N),
        .IDXW       (IDXW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .PhysicalAddress(PhysicalAddress),
        .Size           (Size),
        .ReadAccess     (ReadAccess),
        .WriteAccess    (WriteAccess),
        .ExecuteAccess  (ExecuteAccess),
        .PrivilegeMode  (PrivilegeMode),
        .PMPCfg         (PMPCfg),
        .PMPAdr         (PMPAdr),
        .CfgWrite       (CfgWrite),
        .RspValid       (RspValid),
        .RspReady       (RspReady),
        .Fault          (Fault),
        .Matched        (Matched),
        .MatchIdx       (MatchIdx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit fault;
        bit matched;
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   rsp_delay = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // ---------------------------------------------------------------------
    // Reference model: each entry is turned into a byte range [lo, hi) and
    // the lowest entry whose range holds the address wins.
    // ---------------------------------------------------------------------
    function automatic void model(input logic [PA_BITS-1:0] pa, input logic [1:0] sz,
                                  input bit rd, input bit wr, input bit ex,
                                  input logic [1:0] priv,
                                  output bit f, output bit m, output int idx);
        bit any = 1'b0;
        m   = 1'b0;
        idx = 0;
        f   = 1'b0;
        for (int i = 0; i < N; i++) begin
            longint unsigned lo   = 0;
            longint unsigned span = 0;
            longint unsigned a    = longint'(pa);
            longint unsigned base = longint'({adr[i], 2'b00});
            bit              hit  = 1'b0;
            int              k    = 0;
            if (cfg[i][4:3] != 2'b00) any = 1'b1;
            case (cfg[i][4:3])
                2'b01: begin
                    if (i > 0) lo = longint'({adr[i-1], 2'b00});
                    hit = (a >= lo) && (a < base);
                end
                2'b10: begin
                    span = (sz == 2'b11) ? 8 : 4;
                    base = base & ~(span - 1);
                    hit  = (a >= base) && (a < base + span);
                end
                2'b11: begin
                    while (k < AW && adr[i][k]) k++;
                    span = 64'd1 << (k + 3);
                    base = base & ~(span - 1);
                    hit  = (a >= base) && (a < base + span);
                end
                default: hit = 1'b0;
            endcase
            if (hit) begin
                m   = 1'b1;
                idx = i;
                f   = ((priv != 2'b11) || cfg[i][7]) &&
                      ((rd && !cfg[i][0]) || (wr && !cfg[i][1]) || (ex && !cfg[i][2]));
                return;
            end
        end
        f = (priv != 2'b11) && any;
    endfunction

    // ---------------------------------------------------------------------
    // Driver helpers
    // ---------------------------------------------------------------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ReqReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ReqReady) begin
            check("idle_timeout", ReqReady, 1'b1);
            summary_and_finish();
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            cfg[i] = 8'h00;
            adr[i] = '0;
        end
    endtask

    // acc: 0 read, 1 write, 2 execute. cw: 0 none, >0 CfgWrite in that cycle,
    // -1 CfgWrite in a random scan cycle. dly: RspReady low cycles in RESP.
    task automatic issue(input logic [PA_BITS-1:0] pa, input logic [1:0] sz, input int acc,
                         input logic [1:0] priv, input int cw, input int dly);
        bit f;
        bit m;
        int idx;
        int lat;
        int j;
        int n = 0;
        model(pa, sz, acc == 0, acc == 1, acc == 2, priv, f, m, idx);
        lat = m ? idx + 2 : N + 1;
        j   = (cw < 0) ? int'($urandom_range(1, lat - 1)) : cw;
        wait_idle();
        @(posedge clk);
        #1;
        PhysicalAddress = pa;
        Size            = sz;
        ReadAccess      = (acc == 0);
        WriteAccess     = (acc == 1);
        ExecuteAccess   = (acc == 2);
        PrivilegeMode   = priv;
        ReqValid        = 1'b1;
        rsp_delay       = dly;
        @(negedge clk);
        while (!ReqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ReqReady) begin
            check("accept_timeout", ReqReady, 1'b1);
            ReqValid = 1'b0;
            return;
        end
        sb.push_back('{f, m, idx, int'(cyc) + lat + j});
        @(posedge clk);
        #1;
        // Scramble the request inputs: the DUT must work from its captured copy.
        ReqValid        = 1'b0;
        PhysicalAddress = {2'($urandom), 32'($urandom)};
        Size            = 2'($urandom);
        ReadAccess      = 1'($urandom);
        WriteAccess     = 1'($urandom);
        ExecuteAccess   = 1'($urandom);
        PrivilegeMode   = 2'($urandom);
        if (j > 0) begin
            repeat (j - 1) begin
                @(posedge clk);
                #1;
            end
            CfgWrite = 1'b1;
            @(posedge clk);
            #1;
            CfgWrite = 1'b0;
        end
    endtask

    // ---------------------------------------------------------------------
    // Response acceptor: holds RspReady low for rsp_delay cycles of RESP
    // ---------------------------------------------------------------------
    int hold = 0;
    always @(posedge clk) begin
        #1;
        if (RspValid && !reset) begin
            RspReady = (hold >= rsp_delay);
            hold++;
        end else begin
            hold     = 0;
            RspReady = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    bit   in_rsp    = 1'b0;
    bit   exp_ready = 1'b0;
    exp_t cur       = '{1'b0, 1'b0, 0, 0};

    always @(negedge clk) begin
        if (reset) begin
            check("ready_in_reset", ReqReady, 1'b0);
            in_rsp    = 1'b0;
            exp_ready = 1'b0;
        end else begin
            if (exp_ready) begin
                check("ready_after_handshake", ReqReady, 1'b1);
                exp_ready = 1'b0;
            end
            if (in_rsp) check("valid_held", RspValid, 1'b1);
            if (RspValid) begin
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", RspValid, 1'b0);
                    end else begin
                        cur = sb.pop_front();
                        check("rsp_cycle", 64'(cyc), 64'(cur.cyc));
                    end
                end
                check("fault", Fault, cur.fault);
                check("matched", Matched, cur.matched);
                check("match_idx", MatchIdx, IDXW'(cur.idx));
                check("ready_in_resp", ReqReady, 1'b0);
                if (RspReady) exp_ready = 1'b1;
                in_rsp = !RspReady;
            end else begin
                in_rsp = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        total++;
        bad++;
        summary_and_finish();
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        reset           = 1'b1;
        ReqValid        = 1'b0;
        PhysicalAddress = '0;
        Size            = '0;
        ReadAccess      = 1'b0;
        WriteAccess     = 1'b0;
        ExecuteAccess   = 1'b0;
        PrivilegeMode   = '0;
        CfgWrite        = 1'b0;
        RspReady        = 1'b0;
        clear_cfg();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rspvalid", RspValid, 1'b0);
        check("reset_fault", Fault, 1'b0);
        check("reset_matched", Matched, 1'b0);
        check("reset_matchidx", MatchIdx, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", ReqReady, 1'b1);

        // NAPOT: 2 KiB at 0x80000000, RW only
        cfg[3] = 8'h1B;
        adr[3] = 32'h200000FF;
        issue(34'h080000100, 2'b10, 2, 2'b00, 0, 0);   // U exec -> fault at 3
        issue(34'h080000100, 2'b10, 0, 2'b00, 0, 1);   // U read -> ok
        issue(34'h080000100, 2'b10, 2, 2'b00, 3, 0);   // CfgWrite in cycle 3
        issue(34'h080000100, 2'b10, 2, 2'b00, 0, 4);   // backpressure

        // Reset during SCAN cycle 2 aborts the request
        wait_idle();
        @(posedge clk);
        #1;
        PhysicalAddress = 34'h080000100;
        ExecuteAccess   = 1'b1;
        ReadAccess      = 1'b0;
        WriteAccess     = 1'b0;
        PrivilegeMode   = 2'b00;
        ReqValid        = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_midscan_reset", ReqReady, 1'b1);
        repeat (20) @(posedge clk);
        issue(34'h080000100, 2'b10, 2, 2'b00, 0, 0);

        // TOR: entry 1 covers [0x400, 0x800)
        wait_idle();
        clear_cfg();
        adr[0] = 32'h100;
        cfg[1] = 8'h0F;
        adr[1] = 32'h200;
        issue(34'h7FC, 2'b10, 0, 2'b01, 0, 0);
        issue(34'h800, 2'b10, 0, 2'b01, 0, 0);
        issue(34'h3FC, 2'b11, 1, 2'b01, 0, 2);

        // Priority and M-mode
        wait_idle();
        clear_cfg();
        cfg[2] = 8'h18;
        adr[2] = 32'h3FF;
        cfg[5] = 8'h1F;
        adr[5] = 32'h7FF;
        issue(34'h1000, 2'b10, 1, 2'b01, 0, 0);
        issue(34'h1000, 2'b10, 1, 2'b11, 0, 0);
        wait_idle();
        cfg[2] = 8'h98;
        issue(34'h1000, 2'b10, 1, 2'b11, 0, 0);
        issue(34'h10000, 2'b10, 1, 2'b11, 0, 0);
        issue(34'h10000, 2'b10, 1, 2'b00, -1, 1);

        // NA4 with bit 2 ignored for 8-byte accesses
        wait_idle();
        clear_cfg();
        cfg[7] = 8'h11;
        adr[7] = 32'h401;
        issue(34'h1000, 2'b11, 0, 2'b00, 0, 0);
        issue(34'h1000, 2'b10, 0, 2'b00, 0, 0);
        issue(34'h1004, 2'b10, 0, 2'b00, 0, 0);

        // Random configurations and requests
        for (int t = 0; t < 120; t++) begin
            logic [PA_BITS-1:0] pa;
            logic [1:0]         priv;
            int                 cw;
            if (t % 10 == 0) begin
                wait_idle();
                for (int i = 0; i < N; i++) begin
                    int         r = int'($urandom_range(0, 7));
                    logic [1:0] a = (r < 4) ? 2'b00 : 2'(r - 4);
                    logic [31:0] w = 32'($urandom_range(0, 32'h1000));
                    int         k = int'($urandom_range(0, 8));
                    cfg[i] = {1'($urandom), 2'b00, a, 3'($urandom)};
                    if (a == 2'b11)
                        adr[i] = (w & ~((32'd1 << (k + 1)) - 1)) | ((32'd1 << k) - 1);
                    else
                        adr[i] = w;
                end
            end
            pa = ($urandom_range(0, 7) == 0) ? {2'($urandom), 32'($urandom)}
                                             : 34'($urandom_range(0, 32'h4400));
            case ($urandom_range(0, 2))
                0:       priv = 2'b00;
                1:       priv = 2'b01;
                default: priv = 2'b11;
            endcase
            cw = (cfg[0][4:3] != 2'b01 && $urandom_range(0, 3) == 0) ? -1 : 0;
            issue(pa, 2'($urandom), int'($urandom_range(0, 2)), priv, cw,
                  int'($urandom_range(0, 3)));
        end

        wait_idle();
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        summary_and_finish();
    end

endmodule
